bram_sdp_be: RTL
================

Name: bram_sdp_be

Overview:
- Single-clock simple-dual-port block RAM, parametrised successor to the team's basic dual-port BRAM.
- Adds per-byte write enables, a read-valid handshake, deterministic write-first read-during-write, and a post-reset memory-clear sequencer.
- Sits under FIFO, line-buffer and scratchpad users that need known memory contents after reset.

Parameters:
- ADDR_WIDTH, 11, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-lane count; derived, not overridden.
- CLEAR_VALUE, 0, word written to every address during the clear sequence.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_be  in  BE_WIDTH  byte enables; bit i covers in_data[8i+7:8i].
- wr_addr  in  ADDR_WIDTH  write address.
- in_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- out_data  out  DATA_WIDTH  registered read data.
- out_valid  out  1  one-cycle strobe; out_data is valid for this read.
- init_busy  out  1  high while the clear sequence runs; requests are ignored.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Both are fixed.
- Reset (rst=1 at an edge) sets:
  - state=CLEAR, clear counter=0.
  - init_busy=1, out_valid=0, out_data=0.
  - Memory is not touched in that cycle.
- CLEAR state:
  - Each cycle writes CLEAR_VALUE to mem[cnt], then cnt++.
  - After the write to address 2**ADDR_WIDTH-1, the next state is READY and init_busy drops on the same edge.
  - Total duration: exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - wr_en and rd_en are ignored; no writes, out_valid stays 0.
- READY state, write:
  - When wr_en=1, mem[wr_addr] lane i takes in_data lane i for each wr_be[i]=1; other lanes are kept.
  - wr_be=0 with wr_en=1 is a legal no-op.
- READY state, read:
  - When rd_en=1, next edge gives out_data=mem[rd_addr] and out_valid=1. Latency is 1 cycle.
  - When rd_en=0, out_valid=0 and out_data holds its last value.
  - Back-to-back reads give one valid per cycle.
- Read-during-write to the same address in the same cycle is write-first:
  - Lanes with wr_be=1 return new in_data.
  - Other lanes return stored data.
  - Different addresses are independent.
- rst asserted mid-CLEAR restarts at address 0. rst in READY re-clears the whole memory.
- All addresses are valid. There is no wrap or out-of-range case; the counter is ADDR_WIDTH+1 bits to detect terminal count.

Optional Feature:
- Macro: BRAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage; read latency becomes 2 cycles.
  - out_valid is pipelined to match; both stages reset to 0.
  - The write-first bypass is resolved at stage 1 and propagates unchanged.
  - Throughput stays one read per cycle.
- Undefined: latency is 1 cycle, as above.

Decomposition:
- Package bram_pkg holds:
  - state enum {CLEAR, READY}.
  - BYTE_W=8 constant.
  - Function merge_be(old, new, be) for lane merge, used by the write path and the bypass.
- One natural sub-module, bram_clear_ctrl: owns the FSM and counter, and drives the internal clear write port and init_busy.
- The top level muxes the clear write against the user write.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, CLEAR_VALUE=32'hA5A5A5A5 unless noted):
- Release rst, then read addresses 0..15 when init_busy=0 -> init_busy high for exactly 16 cycles; every read returns 32'hA5A5A5A5 with out_valid one cycle after rd_en.
- Write addr 3 = 32'h11223344 with wr_be=4'b1111, then wr_be=4'b0101 with in_data=32'hFFFFFFFF -> read of addr 3 returns 32'h11FF33FF.
- Write and read addr 7 in the same cycle (old 32'h0, in_data=32'hDEADBEEF, wr_be=4'b0011) -> out_data=32'h0000BEEF next cycle.
- Drive rd_en and wr_en during CLEAR -> no out_valid pulse, and the written address still reads CLEAR_VALUE afterwards.
- Reassert rst at clear cycle 8, and again in READY after writing addr 2 = 32'h1 -> clear restarts (16 more busy cycles); addr 2 reads 32'hA5A5A5A5.
- With BRAM_OUT_REG_EN, 4 back-to-back reads -> out_valid rises 2 cycles after the first rd_en and stays high for 4 cycles with data in order.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled simple-dual-port BRAM.
//
// Contents:
//   state_t  - clear-sequencer states (CLEAR while memory is being
//              initialised, READY once user traffic is accepted).
//   BYTE_W   - width of one byte lane.
//   merge_be - lane merge used by both the write path and the
//              read-during-write bypass.
//
// merge_be works on a fixed maximum width so a single function can serve
// every DATA_WIDTH instantiation. Callers zero-extend their operands and
// truncate the result back to their own width.

package bram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  // Each lane whose enable bit is set takes new_word; all other lanes
  // keep old_word.
  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_clear_ctrl.sv
// Post-reset memory-clear sequencer for bram_sdp_be.
//
// After reset it walks every address once, requesting one clear write per
// cycle, and then drops init_busy for good (until the next reset).
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset; restarts the clear at 0
//   clr_we     out  clear write request for the current clr_addr
//   clr_addr   out  address being cleared this cycle
//   init_busy  out  high while the clear sequence runs

module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  state_t state;
  state_t state_next;

  // One extra bit so the carry out of the last address marks terminal
  // count without a full-width compare.
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The clear write is suppressed while rst is high so the reset cycle
  // leaves memory untouched even if reset lands mid-clear.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    init_busy  = 1'b0;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        clr_we    = !rst;
        cnt_next  = cnt + (ADDR_WIDTH+1)'(1);
        if (cnt_next[ADDR_WIDTH]) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
    endcase
  end

  assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/bram_sdp_be.sv
// Single-clock simple-dual-port block RAM with per-byte write enables,
// write-first read-during-write, a read-valid strobe and a post-reset
// memory clear to CLEAR_VALUE.
//
// Optional feature macro: BRAM_OUT_REG_EN
//   defined   - extra output register stage, read latency 2 cycles
//   undefined - read latency 1 cycle
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset (starts a full clear)
//   wr_en      in   write request
//   wr_be      in   byte enables, bit i covers in_data[8i+7:8i]
//   wr_addr    in   write address
//   in_data    in   write data
//   rd_en      in   read request
//   rd_addr    in   read address
//   out_data   out  registered read data, holds when no read completes
//   out_valid  out  one-cycle strobe per completed read
//   init_busy  out  high during the clear sequence; requests are ignored

module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int                   BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [BE_WIDTH-1:0]   mem_be;

  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_fwd;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  bram_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  // The clear sequencer owns the write port while busy; user writes are
  // only accepted once READY and never in a reset cycle.
  always_comb begin
    mem_we   = wr_en && !rst;
    mem_addr = wr_addr;
    mem_din  = in_data;
    mem_be   = wr_be;
    if (init_busy) begin
      mem_we   = clr_we;
      mem_addr = clr_addr;
      mem_din  = CLEAR_VALUE;
      mem_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= DATA_WIDTH'(merge_be(MAX_DATA_W'(mem[mem_addr]),
                                            MAX_DATA_W'(mem_din),
                                            MAX_BE_W'(mem_be)));
    end
  end

  // Write-first bypass: a read hitting the address being written this
  // cycle sees the enabled lanes of in_data merged over the stored word.
  always_comb begin
    rd_fire = rd_en && !init_busy;
    rd_word = mem[rd_addr];
    rd_fwd  = rd_word;
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_fwd = DATA_WIDTH'(merge_be(MAX_DATA_W'(rd_word),
                                    MAX_DATA_W'(in_data),
                                    MAX_BE_W'(wr_be)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_fwd;
      end
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;

  // Second stage only retimes; the bypass decision was made at stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_data;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
`else
  assign out_valid = s1_valid;
  assign out_data  = s1_data;
`endif

endmodule
